shifter_sequencer: RTL

- FSM controller for the add/subtract significand barrel shifter and its output register.
- Sequences one alignment right-shift by the exponent difference. After the external adder result is ready, it sequences either a 1-bit overflow right-shift (carry-in) or a normalization left-shift by the leading-zero count.
- Drives the shifter's load, shift value, direction, injected bit and data-source mux select, and reports completion to the top-level FPU FSM.

---
 rtl/shifter_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/shifter_sequencer.sv
// Sequencer for the add/sub significand barrel shifter: alignment, overflow or normalisation shift, completion report.
// Optional watchdog on the adder/LZC waits is compiled in with SEQ_TIMEOUT_EN.
module shifter_sequencer #(
    parameter int SWR     = 26,
    parameter int EWR     = 5,
    parameter int EW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [EW-1:0]  exp_diff_i,
    input  logic           add_done_i,
    input  logic           carry_i,
    input  logic           lzc_valid_i,
    input  logic [EWR-1:0] lzc_i,
    output logic           bs_load_o,
    output logic [EWR-1:0] bs_shift_value_o,
    output logic           bs_left_right_o,
    output logic           bs_bit_shift_o,
    output logic           bs_sel_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           zero_o,
    output logic           err_o
);

    typedef enum logic [2:0] {
        IDLE, ALIGN, WAIT_ADD, OVF, WAIT_LZC, NORM, DONE
    } state_t;

    state_t         state_reg, state_next;
    logic           load_next, dir_next, bit_next, sel_next, done_next, zero_next, err_next;
    logic [EWR-1:0] shift_next;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] timer_reg, timer_next;
    logic          timeout_hit;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Outputs are registered from the next state, so each one lines up with the state it decodes.
    always_comb begin
        state_next = state_reg;
        load_next  = 1'b0;
        shift_next = '0;
        dir_next   = 1'b0;
        bit_next   = 1'b0;
        sel_next   = 1'b0;
        done_next  = 1'b0;
        zero_next  = 1'b0;
        err_next   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        timer_next  = timer_reg;
        timeout_hit = (timer_reg == CW'(TIMEOUT - 1));
`endif
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = ALIGN;
                    load_next  = 1'b1;
                    shift_next = (exp_diff_i >= EW'(SWR)) ? EWR'(SWR) : exp_diff_i[EWR-1:0];
                end
            end
            ALIGN: begin
                state_next = WAIT_ADD;
`ifdef SEQ_TIMEOUT_EN
                timer_next = '0;
`endif
            end
            WAIT_ADD: begin
                if (add_done_i) begin
                    if (carry_i) begin
                        state_next = OVF;
                        load_next  = 1'b1;
                        sel_next   = 1'b1;
                        shift_next = EWR'(1);
                        bit_next   = 1'b1;
                    end else begin
                        state_next = WAIT_LZC;
`ifdef SEQ_TIMEOUT_EN
                        timer_next = '0;
`endif
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer_reg + CW'(1);
                end
`endif
            end
            OVF: begin
                state_next = DONE;
                done_next  = 1'b1;
            end
            WAIT_LZC: begin
                if (lzc_valid_i) begin
                    if (lzc_i >= EWR'(SWR)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        zero_next  = 1'b1;
                    end else if (lzc_i == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = NORM;
                        load_next  = 1'b1;
                        sel_next   = 1'b1;
                        dir_next   = 1'b1;
                        shift_next = lzc_i;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer_reg + CW'(1);
                end
`endif
            end
            NORM: begin
                state_next = DONE;
                done_next  = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            bs_load_o        <= 1'b0;
            bs_shift_value_o <= '0;
            bs_left_right_o  <= 1'b0;
            bs_bit_shift_o   <= 1'b0;
            bs_sel_o         <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            zero_o           <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bs_load_o        <= load_next;
            bs_shift_value_o <= shift_next;
            bs_left_right_o  <= dir_next;
            bs_bit_shift_o   <= bit_next;
            bs_sel_o         <= sel_next;
            busy_o           <= (state_next != IDLE);
            done_o           <= done_next;
            zero_o           <= zero_next;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg <= '0;
            err_o     <= 1'b0;
        end else begin
            timer_reg <= timer_next;
            err_o     <= err_next;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
